// File: rtl/aoi_rr_scheduler.sv
// aoi_rr_scheduler
//   Round-robin front end for one shared, registered AND-OR-INVERT unit,
//   F = ~((A&B)|(C&D)). One requester is granted at a time and its operand
//   nibble is latched. The result comes back one cycle later, tagged with
//   the requester index, and is held until the consumer accepts it.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request level
//   opnd       per-requester operands, nibble i = {A,B,C,D} at opnd[4i+3:4i]
//   gnt        one-hot single-cycle grant pulse, only while idle
//   busy       high whenever a transaction is in flight
//   f_valid    result valid
//   out_ready  consumer accepts the result when f_valid & out_ready
//   F          AOI result
//   f_id       index of the requester that owns F
//   done_cnt   completed-handshake counter, wraps
module aoi_rr_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2,
  parameter int unsigned CNTW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] opnd,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               f_valid,
  input  logic               out_ready,
  output logic               F,
  output logic [IDW-1:0]     f_id,
  output logic [CNTW-1:0]    done_cnt
);

  typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

  localparam logic [IDW:0] NReq = (IDW+1)'(N_REQ);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [3:0]       opnd_q;

  logic             any_req;
  logic [IDW:0]     start;
  logic [N_REQ-1:0] rot;
  logic [IDW:0]     off;
  logic [IDW:0]     pos;
  logic [IDW-1:0]   sel;
  logic [3:0]       nib;
  logic             grant_en;

  assign any_req = |req;
  assign busy    = (state_q != StIdle);

  // Rotate the request vector so bit 0 is the requester just after rr_ptr,
  // take the lowest set bit, then map the offset back to an index.
  always_comb begin
    start = {1'b0, rr_ptr_q} + {{IDW{1'b0}}, 1'b1};
    rot   = N_REQ'({req, req} >> start);
    off   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = (IDW+1)'(j);
      end
    end
    pos = start + off;
    if (pos >= NReq) begin
      pos = pos - NReq;
    end
    sel = pos[IDW-1:0];
  end

  always_comb begin
    nib = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == IDW'(i)) begin
        nib = opnd[4*i +: 4];
      end
    end
  end

  // Gated by rst_n so the grant drops immediately while reset is held.
  assign grant_en = rst_n && (state_q == StIdle) && any_req;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = grant_en && (sel == IDW'(i));
    end
  end

  // rr_ptr only moves in idle, so it still names the owner during eval and
  // doubles as the id register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= IDW'(N_REQ - 1);
      opnd_q   <= '0;
      f_valid  <= 1'b0;
      F        <= 1'b0;
      f_id     <= '0;
      done_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            opnd_q   <= nib;
            rr_ptr_q <= sel;
            state_q  <= StEval;
          end
        end
        StEval: begin
          F       <= ~((opnd_q[3] & opnd_q[2]) | (opnd_q[1] & opnd_q[0]));
          f_id    <= rr_ptr_q;
          f_valid <= 1'b1;
          state_q <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            f_valid  <= 1'b0;
            done_cnt <= done_cnt + CNTW'(1);
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aoi_rr_scheduler.sv
module tb_aoi_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] opnd;
  logic [3:0]  gnt;
  logic        busy;
  logic        f_valid;
  logic        out_ready;
  logic        F;
  logic [1:0]  f_id;
  logic [7:0]  done_cnt;

  aoi_rr_scheduler #(.N_REQ(4), .IDW(2), .CNTW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .opnd      (opnd),
    .gnt       (gnt),
    .busy      (busy),
    .f_valid   (f_valid),
    .out_ready (out_ready),
    .F         (F),
    .f_id      (f_id),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a transaction moves through "waiting for grant",
  // "one cycle in the unit" and "holding the result".
  int m_phase;  // 0 waiting, 1 computing, 2 holding
  int m_ptr;    // last granted requester
  int m_nib;
  int m_id;
  int m_F;
  int m_fid;
  int m_fv;
  int m_cnt;
  logic [3:0] last_gnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int aoi(input int n);
    int a, b, c, d;
    a = (n >> 3) & 1;
    b = (n >> 2) & 1;
    c = (n >> 1) & 1;
    d = n & 1;
    return ((a == 1 && b == 1) || (c == 1 && d == 1)) ? 0 : 1;
  endfunction

  task automatic m_reset();
    m_phase = 0;
    m_ptr   = 3;
    m_nib   = 0;
    m_id    = 0;
    m_F     = 0;
    m_fid   = 0;
    m_fv    = 0;
    m_cnt   = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the
  // model by the following rising edge.
  task automatic cyc(input logic [3:0] r, input logic [15:0] o, input logic rdy);
    int s;
    int exp_gnt;
    @(negedge clk);
    req       = r;
    opnd      = o;
    out_ready = rdy;
    #1;
    s       = (m_phase == 0) ? pick(m_ptr, r) : -1;
    exp_gnt = (s >= 0) ? (1 << s) : 0;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("f_valid", 32'(f_valid), 32'(m_fv));
    chk("F", 32'(F), 32'(m_F));
    chk("f_id", 32'(f_id), 32'(m_fid));
    chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
    last_gnt = gnt;
    case (m_phase)
      0: if (s >= 0) begin
        m_nib   = int'((o >> (4 * s)) & 16'hF);
        m_ptr   = s;
        m_id    = s;
        m_phase = 1;
      end
      1: begin
        m_F     = aoi(m_nib);
        m_fid   = m_id;
        m_fv    = 1;
        m_phase = 2;
      end
      default: if (rdy) begin
        m_fv    = 0;
        m_cnt   = (m_cnt + 1) % 256;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'hF;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_f_valid", 32'(f_valid), 0);
    chk("rst_F", 32'(F), 0);
    chk("rst_f_id", 32'(f_id), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    @(negedge clk);
    req   = 4'h0;
    rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    int         idx;
    logic [3:0] nib;
    logic       exp_f;
  } vec_t;

  vec_t vecs[8];
  int   order_q[$];
  int   exp_order[8];

  initial begin
    vecs[0] = '{idx: 0, nib: 4'b1100, exp_f: 1'b0};
    vecs[1] = '{idx: 2, nib: 4'b0101, exp_f: 1'b1};
    vecs[2] = '{idx: 2, nib: 4'b0011, exp_f: 1'b0};
    vecs[3] = '{idx: 2, nib: 4'b1010, exp_f: 1'b1};
    vecs[4] = '{idx: 1, nib: 4'b1111, exp_f: 1'b0};
    vecs[5] = '{idx: 3, nib: 4'b0000, exp_f: 1'b1};
    vecs[6] = '{idx: 1, nib: 4'b1001, exp_f: 1'b1};
    vecs[7] = '{idx: 3, nib: 4'b0111, exp_f: 1'b0};
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst_n     = 1'b0;
    req       = 4'h0;
    opnd      = 16'h0;
    out_ready = 1'b0;
    m_reset();
    #12;
    do_reset();

    // Single-requester transactions from the table.
    for (int t = 0; t < 8; t++) begin
      logic [15:0] o;
      logic [3:0]  r;
      o = 16'($urandom);
      o[4*vecs[t].idx +: 4] = vecs[t].nib;
      r = 4'(1 << vecs[t].idx);
      cyc(r, o, 1'b0);
      chk("vec_gnt", 32'(last_gnt), 32'(r));
      cyc(4'h0, 16'($urandom), 1'b0);
      cyc(4'h0, 16'($urandom), 1'b1);
      chk("vec_F", 32'(F), 32'(vecs[t].exp_f));
      chk("vec_f_id", 32'(f_id), 32'(vecs[t].idx));
      cyc(4'h0, 16'($urandom), 1'b0);
      chk("vec_done_cnt", 32'(done_cnt), 32'(t + 1));
    end

    // Round-robin order with every requester pending.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      cyc(4'hF, 16'($urandom), 1'b1);
      chk("gnt_onehot", 32'($countones(last_gnt) <= 1), 1);
      for (int i = 0; i < 4; i++) begin
        if (last_gnt[i]) order_q.push_back(i);
      end
    end
    chk("rr_count", 32'(order_q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", (i < order_q.size()) ? 32'(order_q[i]) : 32'hFFFF_FFFF,
          32'(exp_order[i]));
    end

    // Consumer stall: result held, no grants while pending.
    cyc(4'hF, 16'($urandom), 1'b0);
    cyc(4'hF, 16'($urandom), 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc(4'hF, 16'($urandom), 1'b0);
      chk("stall_no_gnt", 32'(last_gnt), 0);
      chk("stall_valid", 32'(f_valid), 1);
    end
    cyc(4'hF, 16'($urandom), 1'b1);
    cyc(4'hF, 16'($urandom), 1'b0);
    chk("gnt_after_hs", 32'(last_gnt != 0), 1);
    cyc(4'h0, 16'($urandom), 1'b0);
    cyc(4'h0, 16'($urandom), 1'b1);

    // Operands are sampled only at the grant edge.
    cyc(4'b0010, 16'h00C0, 1'b0);
    chk("samp_gnt", 32'(last_gnt), 32'b0010);
    cyc(4'h0, 16'h0000, 1'b0);
    cyc(4'h0, 16'h0000, 1'b1);
    chk("samp_F", 32'(F), 0);
    chk("samp_f_id", 32'(f_id), 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      cyc(4'($urandom), 16'($urandom), 1'($urandom));
    end

    // Reset in the middle of a transaction.
    for (int c = 0; c < 3; c++) cyc(4'h0, 16'($urandom), 1'b1);
    cyc(4'b0001, 16'($urandom), 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    req   = 4'hF;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_f_valid", 32'(f_valid), 0);
    chk("mid_rst_F", 32'(F), 0);
    chk("mid_rst_f_id", 32'(f_id), 0);
    chk("mid_rst_done_cnt", 32'(done_cnt), 0);
    @(negedge clk);
    req   = 4'h0;
    rst_n = 1'b1;
    m_reset();

    // 256 handshakes wrap the counter back to zero.
    for (int c = 0; c < 256 * 3; c++) begin
      cyc(4'b0001, 16'($urandom), 1'b1);
      if (c == 255 * 3) chk("cnt_255", 32'(done_cnt), 255);
    end
    cyc(4'h0, 16'($urandom), 1'b0);
    chk("cnt_wrap", 32'(done_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
